flash_ctrl: RTL

FLASH_CTRL -- requirements
Module: flash_ctrl

---
 rtl/flash_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/flash_ctrl.sv
// flash_ctrl: command sequencer for a x16 parallel NOR flash (Intel/Sharp
// style command set).  It turns one accepted request into the matching
// series of bus cycles: array read, word program or block erase with
// status polling, error recovery and a one-cycle completion pulse.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   need_to_work      request strobe, sampled only while idle
//   op                00 read, 01 program, 10 block erase, 11 reserved
//   caddr, wdata      word address [22:1] and program data
//   flash_data        last array word read
//   work_done         one-cycle completion pulse
//   busy, err         request in progress / last operation failed
//   fl_addr           flash address pins [22:1]
//   fl_dq_in          flash data bus input
//   fl_dq_out         flash data bus drive value
//   fl_dq_oe          data bus output enable; the tristate lives above
//   fl_ce_n           flash chip enable, active-low
//   fl_oe_n           flash output enable, active-low
//   fl_we_n           flash write enable, active-low
//   fl_byte_n         tied high: x16 mode
//   fl_rp_n           tied high: device not held in reset
//   fl_vpen           tied high: programming enabled
module flash_ctrl #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [15:0] POLL_LIMIT  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        need_to_work,
    input  logic [1:0]  op,
    input  logic [21:0] caddr,
    input  logic [15:0] wdata,
    output logic [15:0] flash_data,
    output logic        work_done,
    output logic        busy,
    output logic        err,
    output logic [21:0] fl_addr,
    input  logic [15:0] fl_dq_in,
    output logic [15:0] fl_dq_out,
    output logic        fl_dq_oe,
    output logic        fl_ce_n,
    output logic        fl_oe_n,
    output logic        fl_we_n,
    output logic        fl_byte_n,
    output logic        fl_rp_n,
    output logic        fl_vpen
);

    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ASSERT, RD_RECOVER, DONE
    } state_t;

    // Sequencer step: names the bus cycle in progress, and therefore the
    // word driven during a write and what follows it.
    typedef enum logic [3:0] {
        SEQ_RD_CMD, SEQ_RD_DATA, SEQ_PG_CMD, SEQ_PG_DATA, SEQ_ER_CMD,
        SEQ_ER_CONF, SEQ_POLL_CMD, SEQ_POLL_RD, SEQ_CLR
    } seq_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state, state_d;
    seq_t        step, step_d;
    logic [3:0]  wait_cnt, wait_d;
    logic [15:0] poll_cnt, poll_d;
    logic [15:0] wdata_q, wdata_d;
    logic [21:0] addr_d;
    logic        sr_ready, sr_ready_d;
    logic        sr_fail, sr_fail_d;
    logic [15:0] data_d;
    logic        err_d;
    logic        busy_d, done_d, ce_n_d, oe_n_d, we_n_d, dq_oe_d;
    logic [15:0] dq_out_d;

    function automatic logic [15:0] cmd_value(input seq_t s, input logic [15:0] wd);
        case (s)
            SEQ_RD_CMD:   return 16'h00FF;
            SEQ_PG_CMD:   return 16'h0040;
            SEQ_PG_DATA:  return wd;
            SEQ_ER_CMD:   return 16'h0020;
            SEQ_ER_CONF:  return 16'h00D0;
            SEQ_POLL_CMD: return 16'h0070;
            SEQ_CLR:      return 16'h0050;
            default:      return 16'h0000;
        endcase
    endfunction

    assign fl_byte_n = 1'b1;
    assign fl_rp_n   = 1'b1;
    assign fl_vpen   = 1'b1;

    // Next-state and next-output logic.  Every pin is computed from the
    // next state and registered below, so the strobes come straight off
    // flops and line up with the state they belong to.
    always_comb begin
        state_d    = state;
        step_d     = step;
        wait_d     = wait_cnt;
        poll_d     = poll_cnt;
        wdata_d    = wdata_q;
        addr_d     = fl_addr;
        sr_ready_d = sr_ready;
        sr_fail_d  = sr_fail;
        data_d     = flash_data;
        err_d      = err;

        unique case (state)
            IDLE: begin
                if (need_to_work) begin
                    addr_d  = caddr;
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    wait_d  = 4'd0;
                    poll_d  = 16'd0;
                    unique case (op)
                        2'b00: begin step_d = SEQ_RD_CMD; state_d = WR_SETUP; end
                        2'b01: begin step_d = SEQ_PG_CMD; state_d = WR_SETUP; end
                        2'b10: begin step_d = SEQ_ER_CMD; state_d = WR_SETUP; end
                        2'b11: begin err_d = 1'b1; state_d = DONE; end
                    endcase
                end
            end
            WR_SETUP: begin
                wait_d  = 4'd0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_d  = 4'd0;
                    state_d = WR_HOLD;
                end else begin
                    wait_d = wait_cnt + 4'd1;
                end
            end
            WR_HOLD: begin
                case (step)
                    SEQ_RD_CMD:   begin step_d = SEQ_RD_DATA;  state_d = RD_ASSERT; end
                    SEQ_PG_CMD:   begin step_d = SEQ_PG_DATA;  state_d = WR_SETUP;  end
                    SEQ_ER_CMD:   begin step_d = SEQ_ER_CONF;  state_d = WR_SETUP;  end
                    SEQ_PG_DATA,
                    SEQ_ER_CONF:  begin step_d = SEQ_POLL_CMD; state_d = WR_SETUP;  end
                    SEQ_POLL_CMD: begin step_d = SEQ_POLL_RD;  state_d = RD_ASSERT; end
                    default:      state_d = DONE;
                endcase
            end
            RD_ASSERT: begin
                // The bus is sampled on the edge that ends the OE window.
                if (wait_cnt == WAIT_LAST) begin
                    wait_d  = 4'd0;
                    state_d = RD_RECOVER;
                    if (step == SEQ_RD_DATA) begin
                        data_d = fl_dq_in;
                    end else begin
                        sr_ready_d = fl_dq_in[7];
                        sr_fail_d  = fl_dq_in[5] | fl_dq_in[4] | fl_dq_in[3] | fl_dq_in[1];
                        poll_d     = poll_cnt + 16'd1;
                    end
                end else begin
                    wait_d = wait_cnt + 4'd1;
                end
            end
            RD_RECOVER: begin
                // Status failure and poll timeout both clear the status
                // register before completing.
                if (step != SEQ_POLL_RD) begin
                    state_d = DONE;
                end else if (sr_ready) begin
                    if (sr_fail) begin
                        err_d   = 1'b1;
                        step_d  = SEQ_CLR;
                        state_d = WR_SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end else if (poll_cnt == POLL_LIMIT) begin
                    err_d   = 1'b1;
                    step_d  = SEQ_CLR;
                    state_d = WR_SETUP;
                end else begin
                    state_d = RD_ASSERT;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        ce_n_d   = (state_d == IDLE) || (state_d == DONE);
        oe_n_d   = (state_d != RD_ASSERT);
        we_n_d   = (state_d != WR_PULSE);
        dq_oe_d  = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        dq_out_d = dq_oe_d ? cmd_value(step_d, wdata_d) : 16'h0000;
    end

    // State, counters, latched request and registered pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            step       <= SEQ_RD_CMD;
            wait_cnt   <= 4'd0;
            poll_cnt   <= 16'd0;
            wdata_q    <= 16'h0000;
            sr_ready   <= 1'b0;
            sr_fail    <= 1'b0;
            flash_data <= 16'h0000;
            err        <= 1'b0;
            busy       <= 1'b0;
            work_done  <= 1'b0;
            fl_addr    <= 22'd0;
            fl_ce_n    <= 1'b1;
            fl_oe_n    <= 1'b1;
            fl_we_n    <= 1'b1;
            fl_dq_oe   <= 1'b0;
            fl_dq_out  <= 16'h0000;
        end else begin
            state      <= state_d;
            step       <= step_d;
            wait_cnt   <= wait_d;
            poll_cnt   <= poll_d;
            wdata_q    <= wdata_d;
            sr_ready   <= sr_ready_d;
            sr_fail    <= sr_fail_d;
            flash_data <= data_d;
            err        <= err_d;
            busy       <= busy_d;
            work_done  <= done_d;
            fl_addr    <= addr_d;
            fl_ce_n    <= ce_n_d;
            fl_oe_n    <= oe_n_d;
            fl_we_n    <= we_n_d;
            fl_dq_oe   <= dq_oe_d;
            fl_dq_out  <= dq_out_d;
        end
    end

endmodule
